// File: rtl/video_timing_rx_pkg.sv
// video_timing_rx_pkg: shared display constants and lock-state encoding
package video_timing_rx_pkg;
    localparam int RGB_W = 16;
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vt_state_e;
endpackage

// File: rtl/video_edge_det.sv
// video_edge_det: registered copy of a level plus its rising-edge strobe
module video_edge_det (
    input  logic pix_clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise
);
    always_ff @(posedge pix_clk or negedge rstn)
        if (!rstn) q <= 1'b0;
        else       q <= d;
    assign rise = d & ~q;
endmodule

// File: rtl/video_timing_rx.sv
// video_timing_rx: measures incoming video timing, tracks pixel position,
// locks on repeated identical frames and captures one probe pixel per frame
module video_timing_rx
    import video_timing_rx_pkg::*;
#(
    parameter int X_BITS      = 13,
    parameter int Y_BITS      = 13,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              pix_clk,
    input  logic              rstn,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [X_BITS-1:0] probe_x,
    input  logic [Y_BITS-1:0] probe_y,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [RGB_W-1:0]  rgb_out,
    output logic [X_BITS-1:0] act_x,
    output logic [Y_BITS-1:0] act_y,
    output logic [X_BITS-1:0] h_act_meas,
    output logic [Y_BITS-1:0] v_act_meas,
    output logic              locked,
    output logic              frame_err,
    output logic [RGB_W-1:0]  probe_rgb,
    output logic              probe_vld
);
    localparam int CW = $clog2(LOCK_FRAMES + 1);

    logic vs_rise, de_rise, line_start, line_end, eval, f_bad, good_same, cap;
    logic started, y_first, have_w, w_bad, sat_q, probe_done;
    logic [X_BITS-1:0] cur_x, width, first_w, f_w, px_q, eff_px;
    logic [Y_BITS-1:0] cur_y, f_v, py_q, eff_py;
    logic [CW-1:0] match_cnt, match_nx;
    vt_state_e state, state_nx;

    video_edge_det u_vs (.pix_clk(pix_clk), .rstn(rstn), .d(vs_in), .q(vs_out), .rise(vs_rise));
    video_edge_det u_de (.pix_clk(pix_clk), .rstn(rstn), .d(de_in), .q(de_out), .rise(de_rise));

    // a frame start with de high also opens a line, so that pixel is (0,0)
    assign line_start = de_in & (de_rise | vs_rise);
    assign line_end   = de_out & (~de_in | vs_rise);
    assign cur_x = line_start ? '0 : (&act_x) ? act_x : act_x + 1'b1;
    assign cur_y = !line_start ? act_y : (vs_rise | y_first) ? '0 : (&act_y) ? act_y : act_y + 1'b1;
    assign width = act_x + 1'b1;

    // verdict on the frame closing at this vs edge, including a line cut by it
    assign f_w       = have_w ? first_w : width;
    assign f_v       = act_y + 1'b1;
    assign f_bad     = !(have_w | line_end) | w_bad | sat_q | (line_end & have_w & (width != first_w));
    assign good_same = !f_bad & (f_w == h_act_meas) & (f_v == v_act_meas);
    assign eval      = vs_rise & started;

    assign eff_px = vs_rise ? probe_x : px_q;
    assign eff_py = vs_rise ? probe_y : py_q;
    assign cap    = de_in & (started | vs_rise) & (vs_rise | !probe_done) & (cur_x == eff_px) & (cur_y == eff_py);

    assign locked = state == LOCKED;

    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        if (vs_rise)
            case (state)
                SEARCH: begin
                    state_nx = MEASURE;
                    match_nx = '0;
                end
                MEASURE: begin
                    match_nx = good_same ? match_cnt + 1'b1 : '0;
                    if (good_same && 32'(match_cnt) + 1 >= LOCK_FRAMES - 1) state_nx = LOCKED;
                end
                default: if (!good_same) begin
                    state_nx = SEARCH;
                    match_nx = '0;
                end
            endcase
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            started    <= 1'b0;
            y_first    <= 1'b0;
            have_w     <= 1'b0;
            w_bad      <= 1'b0;
            sat_q      <= 1'b0;
            probe_done <= 1'b0;
            first_w    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            act_x      <= '0;
            act_y      <= '0;
            h_act_meas <= '0;
            v_act_meas <= '0;
            hs_out     <= 1'b0;
            rgb_out    <= '0;
            frame_err  <= 1'b0;
            probe_rgb  <= '0;
            probe_vld  <= 1'b0;
        end else begin
            state      <= state_nx;
            match_cnt  <= match_nx;
            started    <= started | vs_rise;
            y_first    <= line_start ? 1'b0 : vs_rise | y_first;
            if (de_in) begin
                act_x <= cur_x;
                act_y <= cur_y;
            end
            have_w     <= !vs_rise & (have_w | line_end);
            w_bad      <= !vs_rise & (w_bad | (line_end & have_w & (width != first_w)));
            if (line_end & !have_w) first_w <= width;
            sat_q      <= !vs_rise & (sat_q | (de_in & ((&cur_x) | (&cur_y))));
            if (vs_rise) begin
                px_q <= probe_x;
                py_q <= probe_y;
            end
            probe_done <= cap | (probe_done & !vs_rise);
            probe_vld  <= cap;
            if (cap) probe_rgb <= rgb_in;
            frame_err  <= eval & f_bad;
            if (eval & !f_bad) begin
                h_act_meas <= f_w;
                v_act_meas <= f_v;
            end
            hs_out     <= hs_in;
            rgb_out    <= rgb_in;
        end
    end
endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: directed frame table plus randomized frames against a
// frame-level reference model of measurement, lock, position and probe capture
module tb_video_timing_rx;
    localparam int XB = 13, YB = 13, LF = 2;
    localparam int XMAX = (1 << XB) - 1, YMAX = (1 << YB) - 1;

    logic pix_clk = 1'b0, rstn = 1'b0, vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [15:0] rgb_in = '0;
    logic [XB-1:0] probe_x = '0;
    logic [YB-1:0] probe_y = '0;
    logic vs_out, hs_out, de_out, locked, frame_err, probe_vld;
    logic [15:0] rgb_out, probe_rgb;
    logic [XB-1:0] act_x, h_act_meas;
    logic [YB-1:0] act_y, v_act_meas;

    video_timing_rx #(.X_BITS(XB), .Y_BITS(YB), .LOCK_FRAMES(LF)) dut (
        .pix_clk(pix_clk), .rstn(rstn), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y), .vs_out(vs_out),
        .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out), .act_x(act_x), .act_y(act_y),
        .h_act_meas(h_act_meas), .v_act_meas(v_act_meas), .locked(locked),
        .frame_err(frame_err), .probe_rgb(probe_rgb), .probe_vld(probe_vld)
    );

    always #5 pix_clk = ~pix_clk;

    int total = 0, bad = 0, err_seen = 0, pv_seen = 0, vs_cnt = 0;
    // reference model: frame-level bookkeeping (state 0 search, 1 measure, 2 locked)
    bit m_started, m_wbad, m_ptaken, prev_vs, e_err;
    int m_st, m_match, m_h, m_v, m_lines, m_w0, m_px, m_py;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic void model_reset();
        m_started = 0; m_wbad = 0; m_ptaken = 0; prev_vs = 0; e_err = 0;
        m_st = 0; m_match = 0; m_h = 0; m_v = 0; m_lines = 0; m_w0 = 0;
    endfunction

    function automatic void model_frame_start();
        bit good, same;
        good = m_lines > 0 && !m_wbad && m_w0 <= XMAX && m_lines <= YMAX;
        same = good && m_w0 == m_h && m_lines == m_v;
        e_err = m_started && !good;
        if (!m_started) begin
            m_started = 1; m_st = 1; m_match = 0;
        end else begin
            if (good) begin m_h = m_w0; m_v = m_lines; end
            if (m_st == 0) begin m_st = 1; m_match = 0; end
            else if (m_st == 1) begin
                m_match = same ? m_match + 1 : 0;
                if (same && m_match >= LF - 1) m_st = 2;
            end else if (!same) begin m_st = 0; m_match = 0; end
        end
        m_lines = 0; m_wbad = 0; m_ptaken = 0;
        m_px = int'(probe_x); m_py = int'(probe_y);
    endfunction

    function automatic void model_line(input int w);
        if (m_lines == 0) m_w0 = w;
        else if (w != m_w0) m_wbad = 1;
        m_lines++;
    endfunction

    task automatic step(input bit de, input int x, input int y);
        bit rise, exp_vld;
        logic [31:0] xv, yv;
        logic [15:0] rgb;
        int xs;
        vs_in = vs_cnt > 0;
        if (vs_cnt > 0) vs_cnt--;
        rise = vs_in && !prev_vs;
        prev_vs = vs_in;
        if (rise) model_frame_start();
        xv = x; yv = y;
        xs = x > XMAX ? XMAX : x;
        rgb = de ? {yv[7:0], xv[7:0]} : 16'($urandom);
        hs_in = !de && $urandom_range(0, 3) == 0;
        de_in = de;
        rgb_in = rgb;
        exp_vld = de && m_started && !m_ptaken && xs == m_px && y == m_py;
        if (exp_vld) m_ptaken = 1;
        @(posedge pix_clk);
        #1;
        if (frame_err === 1'b1) err_seen++;
        if (probe_vld === 1'b1) pv_seen++;
        chk("frame_err", 32'(frame_err), 32'(rise && e_err));
        chk("locked", 32'(locked), 32'(m_st == 2));
        if (rise) begin
            chk("h_act_meas", 32'(h_act_meas), m_h);
            chk("v_act_meas", 32'(v_act_meas), m_v);
        end
        chk("vs_out", 32'(vs_out), 32'(vs_in));
        chk("hs_out", 32'(hs_out), 32'(hs_in));
        chk("de_out", 32'(de_out), 32'(de));
        chk("rgb_out", 32'(rgb_out), 32'(rgb));
        if (de && m_started) begin
            chk("act_x", 32'(act_x), xs);
            chk("act_y", 32'(act_y), y);
        end
        chk("probe_vld", 32'(probe_vld), 32'(exp_vld));
        if (exp_vld) chk("probe_rgb", 32'(probe_rgb), 32'(rgb));
    endtask

    // one frame: vs pulse, optional line bl of width bw, probe moved after line 0
    task automatic frame(input int w, input int h, input int bl, input int bw, input bit vs_de);
        int lw;
        vs_cnt = 3;
        if (!vs_de || h == 0) repeat ($urandom_range(3, 6)) step(0, 0, 0);
        for (int l = 0; l < h; l++) begin
            if (l > 0 || !vs_de) repeat ($urandom_range(2, 5)) step(0, 0, 0);
            lw = l == bl ? bw : w;
            for (int x = 0; x < lw; x++) step(1, x, l);
            model_line(lw);
            if (l == 0) begin
                probe_x = XB'($urandom_range(0, 40));
                probe_y = YB'($urandom_range(0, 12));
            end
        end
        repeat (4) step(0, 0, 0);
    endtask

    task automatic check_all_zero(input string n);
        chk({n, " flags"}, 32'(|{vs_out, hs_out, de_out, locked, frame_err, probe_vld}), 0);
        chk({n, " data"}, 32'(|{rgb_out, probe_rgb, act_x, act_y, h_act_meas, v_act_meas}), 0);
    endtask

    typedef struct {
        int w, h, bl, bw;
        bit vs_de;
        int px, py;
        int e_err, e_lock, e_h, e_v, e_pv;
    } vec_t;
    vec_t tv[17];

    int e0, p0, w, h, bl, bw;

    initial begin
        // expectations describe the frame verdict taken at this entry's own vs edge
        tv[0]  = '{20, 8, -1, 0, 0, 5, 3, 0, 0, 0, 0, 1};
        tv[1]  = '{20, 8, -1, 0, 0, 5, 3, 0, 0, 20, 8, 1};
        tv[2]  = '{20, 8, -1, 0, 0, 19, 7, 0, 1, 20, 8, 1};
        tv[3]  = '{20, 8, 5, 19, 0, 5, 3, 0, 1, 20, 8, 1};
        tv[4]  = '{20, 8, -1, 0, 0, 30, 3, 1, 0, 20, 8, 0};
        tv[5]  = '{20, 8, -1, 0, 0, 0, 0, 0, 0, 20, 8, 1};
        tv[6]  = '{28, 10, -1, 0, 0, 5, 3, 0, 1, 20, 8, 1};
        tv[7]  = '{28, 10, -1, 0, 0, 5, 3, 0, 0, 28, 10, 1};
        tv[8]  = '{28, 10, -1, 0, 0, 5, 3, 0, 0, 28, 10, 1};
        tv[9]  = '{28, 10, -1, 0, 1, 0, 0, 0, 1, 28, 10, 1};
        tv[10] = '{20, 8, -1, 0, 0, 5, 3, 0, 1, 28, 10, 1};
        tv[11] = '{20, 8, -1, 0, 0, 5, 3, 0, 0, 20, 8, 1};
        tv[12] = '{20, 0, -1, 0, 0, 5, 3, 0, 0, 20, 8, 0};
        tv[13] = '{20, 8, -1, 0, 0, 5, 3, 1, 0, 20, 8, 1};
        tv[14] = '{20, 8, -1, 0, 0, 5, 3, 0, 1, 20, 8, 1};
        tv[15] = '{9000, 1, -1, 0, 0, 8191, 0, 0, 1, 20, 8, 1};
        tv[16] = '{20, 8, -1, 0, 0, 5, 3, 1, 0, 20, 8, 1};
        model_reset();
        repeat (3) @(posedge pix_clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            probe_x = XB'(tv[i].px);
            probe_y = YB'(tv[i].py);
            e0 = err_seen;
            p0 = pv_seen;
            frame(tv[i].w, tv[i].h, tv[i].bl, tv[i].bw, tv[i].vs_de);
            chk($sformatf("t%0d frame_err pulses", i), err_seen - e0, tv[i].e_err);
            chk($sformatf("t%0d locked", i), 32'(locked), tv[i].e_lock);
            chk($sformatf("t%0d h_act_meas", i), 32'(h_act_meas), tv[i].e_h);
            chk($sformatf("t%0d v_act_meas", i), 32'(v_act_meas), tv[i].e_v);
            chk($sformatf("t%0d probe_vld pulses", i), pv_seen - p0, tv[i].e_pv);
            if (tv[i].e_pv == 1)
                chk($sformatf("t%0d probe_rgb", i), 32'(probe_rgb), ((tv[i].py & 255) << 8) | (tv[i].px & 255));
        end
        for (int f = 0; f < 25; f++) begin
            probe_x = XB'($urandom_range(0, 22));
            probe_y = YB'($urandom_range(0, 9));
            w  = 20 + $urandom_range(0, 1);
            h  = $urandom_range(0, 9) == 0 ? 0 : 8 + $urandom_range(0, 1);
            bl = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : -1;
            bw = w + 2 * $urandom_range(0, 1) - 1;
            frame(w, h, bl, bw, 1'($urandom_range(0, 1)));
        end
        // reset in the middle of a line, then a clean relock
        vs_cnt = 3;
        repeat (4) step(0, 0, 0);
        for (int x = 0; x < 10; x++) step(1, x, 0);
        #2 rstn = 1'b0;
        #1 check_all_zero("mid-line reset");
        model_reset();
        vs_in = 1'b0;
        vs_cnt = 0;
        repeat (2) @(posedge pix_clk);
        #1 rstn = 1'b1;
        for (int x = 10; x < 20; x++) step(1, x, 0);
        repeat (5) step(0, 0, 0);
        probe_x = XB'(5);
        probe_y = YB'(3);
        for (int f = 0; f < 3; f++) frame(20, 8, -1, 0, 0);
        chk("relock locked", 32'(locked), 1);
        chk("relock h_act_meas", 32'(h_act_meas), 20);
        chk("relock v_act_meas", 32'(v_act_meas), 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_timing_rx.md
VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- X_BITS, 13, width of the horizontal position and measurement fields.
- Y_BITS, 13, width of the vertical position and measurement fields.
- LOCK_FRAMES, 2, number of consecutive identical good frames required to lock.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- pix_clk, in, 1, the only clock.
- rstn, in, 1, asynchronous active-low reset.
- vs_in, in, 1, vertical sync (active high).
- hs_in, in, 1, horizontal sync (active high).
- de_in, in, 1, data enable.
- rgb_in, in, 16, RGB565 pixel.
- probe_x, in, X_BITS, probe column.
- probe_y, in, Y_BITS, probe row.
- vs_out / hs_out / de_out, out, 1 each, inputs delayed by 1 cycle.
- rgb_out, out, 16, rgb_in delayed by 1 cycle.
- act_x, out, X_BITS, column of the pixel on rgb_out.
- act_y, out, Y_BITS, row of the pixel on rgb_out.
- h_act_meas, out, X_BITS, active width of the last good frame.
- v_act_meas, out, Y_BITS, active line count of the last good frame.
- locked, out, 1, stable timing indicator.
- frame_err, out, 1, one-cycle pulse when a frame is rejected.
- probe_rgb, out, 16, pixel captured at (probe_x, probe_y).
- probe_vld, out, 1, one-cycle pulse when probe_rgb updates.

Function
REQ-003 Frame start SHALL be a vs_in rising edge, detected against a registered copy of vs_in.
REQ-004 Line start SHALL be a de_in rising edge; active pixels SHALL be the cycles with de_in high.
REQ-005 Position outputs SHALL have 1-cycle latency, aligned with de_out: act_x = 0 on the first pixel of a line and increments each active pixel; act_y = 0 on the first line after frame start and increments on each subsequent line start.
REQ-006 act_x and act_y SHALL hold their last values while de_out is low.
REQ-007 The horizontal counter SHALL saturate at all-ones and SHALL NOT wrap.
REQ-008 The vertical counter SHALL saturate at all-ones and SHALL NOT wrap.
REQ-009 Per frame, the block SHALL record the width of the first line and SHALL flag the frame bad if any later line width differs.
REQ-010 A frame SHALL also be flagged bad if either counter saturates or the frame contains zero lines.
REQ-011 At each frame start after the first, the completed frame SHALL be evaluated:
- Good frame: h_act_meas and v_act_meas update on the next cycle.
- Bad frame: frame_err pulses for 1 cycle and h_act_meas / v_act_meas hold.
REQ-012 The state machine SHALL have the states SEARCH, MEASURE and LOCKED:
- SEARCH: go to MEASURE at the first frame start.
- MEASURE: on a good frame matching the previous good measurement, increment the match counter; on reaching LOCK_FRAMES-1 matches, go to LOCKED.
- MEASURE: on a bad or mismatching frame, clear the match counter and stay in MEASURE.
- LOCKED: on a bad or mismatching frame, go to SEARCH and clear the match counter.
REQ-013 locked SHALL be 1 only in LOCKED, registered, and SHALL drop on the same cycle frame_err asserts.
REQ-014 Probe capture: when de_in is high and the internal x/y counters equal probe_x/probe_y, rgb_in SHALL be captured and probe_vld pulsed 1 cycle later, at most once per frame.
REQ-015 Probe coordinates SHALL be sampled at frame start; changes mid-frame take effect at the next frame.
REQ-016 A frame start coincident with de_in high SHALL be treated as frame start first, with that pixel becoming x=0, y=0.

Reset
REQ-017 While rstn is low, the block SHALL be in SEARCH and every output and counter SHALL be 0, including locked, frame_err, probe_vld and the measurements.
REQ-018 Reset deassertion mid-frame SHALL discard the partial frame; measurement restarts at the next vs_in rising edge.

Structure
REQ-019 The state encoding SHALL live in the shared display package.
REQ-020 The RGB565 width constant SHALL live in the shared display package.
REQ-021 One sub-module, video_edge_det (registered rising-edge detector), SHALL be instantiated twice, for vs_in and de_in.

Verification
REQ-022 640x480 timing for 3 frames, LOCK_FRAMES=2 -> locked=1 after the 3rd vs rise; h_act_meas=640; v_act_meas=480.
REQ-023 Locked stream with line 100 shortened to 639 pixels -> frame_err pulse at the next vs rise; locked=0; measurements stay 640/480.
REQ-024 probe=(5,3), rgb_in = {y[7:0],x[7:0]} -> probe_rgb=16'h0305; exactly one probe_vld per frame.
REQ-025 Resolution change 640x480 to 800x600 -> SEARCH, then re-lock; measurements become 800/600.
REQ-026 rstn pulsed low mid-line -> all outputs 0 immediately; clean re-lock after 3 further frames.
REQ-027 de_in held high for more than 2^13 cycles -> act_x saturates at 8191; frame rejected with frame_err.
